// File: rtl/serial_tagger_pkg.sv
// Shared types for the serial tagger: default payload/keep words and the credit-count width helper.
// Pure declarations; no timing or flow-control behaviour lives here.
package serial_tagger_pkg;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [KEEP_W-1:0] keep_t;

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/serial_tagger_credit.sv
// DEPTH-bounded up/down credit counter; count updates one cycle after inc/dec.
// inc is ignored at full and dec at empty; underflow flags a dec seen while empty.
module tag_credit_counter
    import serial_tagger_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          underflow
);

    logic inc_ok;
    logic dec_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign inc_ok    = inc && !full;
    assign dec_ok    = dec && !empty;
    assign underflow = dec && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/serial_tagger.sv
// Stamps in-order beats with a wrapping serial tag, 1-cycle registered in->out, 1 beat/cycle.
// in_rdy drops when the output slot is held (out_rdy low) or DEPTH tags are in flight.
module serial_tagger
    import serial_tagger_pkg::*;
#(
    parameter type data_t       = word_t,
    parameter int  DEPTH        = 16,
    parameter int  SERIAL_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  data_t                       in_dat,
    input  keep_t                       in_keep,
    input  logic                        in_last,
    input  logic                        in_vld,
    output logic                        in_rdy,
    output data_t                       out_dat,
    output keep_t                       out_keep,
    output logic                        out_last,
    output logic [SERIAL_WIDTH-1:0]     out_tag,
    output logic                        out_vld,
    input  logic                        out_rdy,
    input  logic                        retire,
    output logic [$clog2(DEPTH+1)-1:0]  in_flight,
    output logic                        idle,
    output logic                        retire_err
);

    if ((DEPTH < 2) || (2 ** SERIAL_WIDTH != DEPTH)) begin : g_bad_cfg
        $error("serial_tagger: DEPTH must be a power of two >= 2 and equal 2**SERIAL_WIDTH");
    end

    logic                    accept;
    logic                    slot_free;
    logic                    cnt_full;
    logic                    cnt_empty;
    logic                    cnt_underflow;
    logic [SERIAL_WIDTH-1:0] next_tag;

    // Credit comes from the registered count only, so retire never reaches in_rdy combinationally.
    assign slot_free = !out_vld || out_rdy;
    assign in_rdy    = slot_free && !cnt_full;
    assign accept    = in_vld && in_rdy;
    assign idle      = cnt_empty && !out_vld;

    tag_credit_counter #(
        .DEPTH (DEPTH),
        .CW    ($clog2(DEPTH+1))
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept),
        .dec       (retire),
        .count     (in_flight),
        .full      (cnt_full),
        .empty     (cnt_empty),
        .underflow (cnt_underflow)
    );

    // Tag wraps DEPTH-1 -> 0 naturally because its width is exactly log2(DEPTH).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            next_tag <= '0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            next_tag <= next_tag + 1'b1;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            out_dat  <= in_dat;
            out_keep <= in_keep;
            out_last <= in_last;
            out_tag  <= next_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_err <= 1'b0;
        end else if (cnt_underflow) begin
            retire_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tagger.sv
// Directed bench for serial_tagger (DEPTH=16) plus a reorder-buffer loopback with random delays.
module tb_serial_tagger;
    import serial_tagger_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    word_t       in_dat = '0;
    keep_t       in_keep = '0;
    logic        in_last = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    word_t       out_dat;
    keep_t       out_keep;
    logic        out_last;
    logic [3:0]  out_tag;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic        retire = 1'b0;
    logic [4:0]  in_flight;
    logic        idle;
    logic        retire_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_tagger #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_dat     (in_dat),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_dat    (out_dat),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_tag    (out_tag),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .retire     (retire),
        .in_flight  (in_flight),
        .idle       (idle),
        .retire_err (retire_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reorder-buffer model state for the loopback phase
    logic        rb_occ [16];
    int          rb_due [16];
    logic [31:0] rb_dat [16];
    logic [3:0]  exp_tag;
    int          sent;
    int          rcvd;
    int          cyc;

    initial begin
        // Reset state
        tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_idle", idle, 1);
        chk("rst_retire_err", retire_err, 0);
        chk("rst_in_rdy", in_rdy, 1);
        rst = 1'b0;
        tick();

        // Five beats, tags 0..4
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; in_dat = 32'(100 + i); in_keep = 4'(i + 1); in_last = (i == 4);
            #1 chk("s5_in_rdy", in_rdy, 1);
            tick();
            chk("s5_tag", out_tag, i);
            chk("s5_dat", out_dat, 100 + i);
            chk("s5_keep", out_keep, i + 1);
            chk("s5_last", out_last, (i == 4));
        end
        in_vld = 1'b0;
        tick();
        chk("s5_vld_drop", out_vld, 0);
        chk("s5_in_flight", in_flight, 5);
        chk("s5_idle", idle, 0);

        // Fill to 16 in flight; tag 4 -> 15 continues across last
        for (int i = 5; i < 16; i++) begin
            in_vld = 1'b1; in_dat = 32'(100 + i); in_last = 1'b0;
            tick();
            chk("fill_tag", out_tag, i);
        end
        in_dat = 32'd116;
        #1;
        chk("full_in_rdy", in_rdy, 0);
        chk("full_in_flight", in_flight, 16);
        chk("full_tag", out_tag, 15);
        tick();
        chk("full_vld_drop", out_vld, 0);
        chk("full_still_stall", in_rdy, 0);
        retire = 1'b1;
        #1 chk("retire_no_comb", in_rdy, 0);
        tick();
        retire = 1'b0;
        chk("retire_in_flight", in_flight, 15);
        chk("retire_reopen", in_rdy, 1);
        tick();
        in_vld = 1'b0;
        chk("wrap_tag", out_tag, 0);
        chk("wrap_dat", out_dat, 116);
        chk("wrap_in_flight", in_flight, 16);
        retire = 1'b1;
        repeat (16) tick();
        retire = 1'b0;
        chk("drain_in_flight", in_flight, 0);

        // Backpressure: held beat stays stable, next follows back-to-back
        out_rdy = 1'b0; in_vld = 1'b1; in_dat = 32'd200;
        tick();
        in_dat = 32'd201;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_rdy", in_rdy, 0);
            chk("bp_vld", out_vld, 1);
            chk("bp_dat", out_dat, 200);
            chk("bp_tag", out_tag, 1);
            tick();
        end
        out_rdy = 1'b1;
        #1 chk("bp_release_rdy", in_rdy, 1);
        tick();
        in_vld = 1'b0;
        chk("bp_next_tag", out_tag, 2);
        chk("bp_next_dat", out_dat, 201);
        tick();
        chk("bp_in_flight", in_flight, 2);

        // Simultaneous accept and retire at 7
        in_vld = 1'b1;
        repeat (5) tick();
        in_vld = 1'b0;
        tick();
        chk("pre_sim_in_flight", in_flight, 7);
        in_vld = 1'b1; retire = 1'b1;
        tick();
        in_vld = 1'b0; retire = 1'b0;
        chk("sim_in_flight", in_flight, 7);
        retire = 1'b1;
        repeat (7) tick();
        retire = 1'b0;
        chk("empty_in_flight", in_flight, 0);
        chk("empty_idle", idle, 1);
        chk("no_err_yet", retire_err, 0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk("under_in_flight", in_flight, 0);
        chk("under_err", retire_err, 1);
        tick();
        chk("under_err_sticky", retire_err, 1);

        // Async reset mid-burst
        in_vld = 1'b1;
        repeat (9) tick();
        in_vld = 1'b0; out_rdy = 1'b0;
        chk("mid_in_flight", in_flight, 9);
        chk("mid_vld", out_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", out_vld, 0);
        chk("arst_in_flight", in_flight, 0);
        chk("arst_err", retire_err, 0);
        tick();
        rst = 1'b0; out_rdy = 1'b1; in_vld = 1'b1; in_dat = 32'd300;
        tick();
        in_vld = 1'b0;
        chk("arst_tag0", out_tag, 0);
        chk("arst_dat", out_dat, 300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Loopback through a modelled reorder buffer
        for (int t = 0; t < 16; t++) begin
            rb_occ[t] = 1'b0; rb_due[t] = 0; rb_dat[t] = '0;
        end
        exp_tag = '0; sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 50000) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            in_vld  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_dat  = 32'(sent);
            if (rb_occ[exp_tag] && rb_due[exp_tag] <= cyc) begin
                retire = 1'b1;
                chk("lb_order", rb_dat[exp_tag], rcvd);
                rb_occ[exp_tag] = 1'b0;
                exp_tag = exp_tag + 1'b1;
                rcvd++;
            end else begin
                retire = 1'b0;
            end
            #1;
            if (in_vld && in_rdy) sent++;
            if (out_vld && out_rdy) begin
                chk("lb_tag_reuse", rb_occ[out_tag], 0);
                rb_occ[out_tag] = 1'b1;
                rb_dat[out_tag] = out_dat;
                rb_due[out_tag] = cyc + 1 + int'($urandom_range(0, 20));
            end
            tick();
            cyc++;
        end
        retire = 1'b0; in_vld = 1'b0;
        chk("lb_count", rcvd, 1000);
        tick();
        chk("lb_end_in_flight", in_flight, 0);
        chk("lb_end_idle", idle, 1);
        chk("lb_end_err", retire_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
